// File: rtl/aer_multi_input_if.sv
// Dual-rail four-phase AER link: two data rails out, one acknowledge back.
interface aer_multi_input_if;
  logic bit0;
  logic bit1;
  logic ack;

  modport master (output bit0, output bit1, input ack);
  modport slave  (input bit0, input bit1, output ack);
endinterface

// File: rtl/aer_multi_input.sv
// AER transmit front end: synchronises up/down spikes from NUM_CH channels,
// arbitrates round-robin and sends each event as a dual-rail four-phase packet.
module aer_multi_input #(
  parameter int unsigned NUM_CH      = 4,
  parameter int unsigned ADDR_W      = 2,
  parameter int unsigned ACK_TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NUM_CH-1:0] ch_up,
  input  logic [NUM_CH-1:0] ch_down,
  aer_multi_input_if.master link,
  output logic              busy,
  output logic [ADDR_W-1:0] cur_addr,
  output logic              timeout_err,
  output logic [7:0]        drop_count
);

  localparam int unsigned PTR_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int unsigned SYM_W = ADDR_W + 1;
  localparam int unsigned REM_W = $clog2(ADDR_W + 1);
  localparam int unsigned CNT_W = 16;

  typedef enum logic [1:0] {IDLE, DRIVE, RELEASE} state_t;

  state_t             state_q, state_nxt;
  logic [NUM_CH-1:0]  up_s1, up_s2, up_s3, dn_s1, dn_s2, dn_s3;
  logic               ack_s1, ack_sync;
  logic [NUM_CH-1:0]  up_rise, dn_rise;
  logic [NUM_CH-1:0]  up_pend, dn_pend, up_pend_nxt, dn_pend_nxt;
  logic [NUM_CH-1:0]  clr_up, clr_dn, req;
  logic [PTR_W-1:0]   rr_ptr, rr_ptr_nxt, gnt_idx;
  logic               gnt_valid;
  logic [31:0]        arb_pos;
  logic [ADDR_W-1:0]  gnt_addr, cur_addr_nxt;
  logic [SYM_W-1:0]   sh_q, sh_nxt, sym_load;
  logic [REM_W-1:0]   rem_q, rem_nxt;
  logic [CNT_W-1:0]   cnt_q, cnt_nxt;
  logic               bit0_q, bit1_q, bit0_nxt, bit1_nxt;
  logic               busy_nxt, tmo_nxt;
  logic [31:0]        drop_n, drop_sum;
  logic [7:0]         drop_nxt;

  assign link.bit0 = bit0_q;
  assign link.bit1 = bit1_q;

  // Two-flop synchronisers plus a history flop for edge detection
  always_ff @(posedge clk) begin
    if (reset) begin
      up_s1    <= '0;
      up_s2    <= '0;
      up_s3    <= '0;
      dn_s1    <= '0;
      dn_s2    <= '0;
      dn_s3    <= '0;
      ack_s1   <= 1'b0;
      ack_sync <= 1'b0;
    end else begin
      up_s1    <= ch_up;
      up_s2    <= up_s1;
      up_s3    <= up_s2;
      dn_s1    <= ch_down;
      dn_s2    <= dn_s1;
      dn_s3    <= dn_s2;
      ack_s1   <= link.ack;
      ack_sync <= ack_s1;
    end
  end

  assign up_rise = up_s2 & ~up_s3;
  assign dn_rise = dn_s2 & ~dn_s3;
  assign req     = up_pend | dn_pend;

  // Round-robin search from rr_ptr; descending loop leaves the nearest requester
  always_comb begin
    gnt_valid = 1'b0;
    gnt_idx   = '0;
    arb_pos   = '0;
    for (int j = int'(NUM_CH) - 1; j >= 0; j--) begin
      arb_pos = 32'(rr_ptr) + 32'(j);
      if (arb_pos >= 32'(NUM_CH)) arb_pos = arb_pos - 32'(NUM_CH);
      if (req[arb_pos[PTR_W-1:0]]) begin
        gnt_valid = 1'b1;
        gnt_idx   = arb_pos[PTR_W-1:0];
      end
    end
  end

  assign gnt_addr = ADDR_W'(gnt_idx);
  assign sym_load = {gnt_addr, up_pend[gnt_idx]};

  // Packet sequencer: next state, rails and datapath loads
  always_comb begin
    state_nxt    = state_q;
    bit0_nxt     = bit0_q;
    bit1_nxt     = bit1_q;
    sh_nxt       = sh_q;
    rem_nxt      = rem_q;
    cnt_nxt      = cnt_q;
    cur_addr_nxt = cur_addr;
    rr_ptr_nxt   = rr_ptr;
    tmo_nxt      = 1'b0;
    clr_up       = '0;
    clr_dn       = '0;

    case (state_q)
      IDLE: begin
        bit0_nxt = 1'b0;
        bit1_nxt = 1'b0;
        if (gnt_valid) begin
          sh_nxt       = sym_load;
          rem_nxt      = REM_W'(ADDR_W);
          cnt_nxt      = '0;
          cur_addr_nxt = gnt_addr;
          rr_ptr_nxt   = (gnt_idx == PTR_W'(NUM_CH - 1)) ? '0 : gnt_idx + PTR_W'(1);
          if (up_pend[gnt_idx]) clr_up[gnt_idx] = 1'b1;
          else                  clr_dn[gnt_idx] = 1'b1;
          bit1_nxt     = sym_load[SYM_W-1];
          bit0_nxt     = ~sym_load[SYM_W-1];
          state_nxt    = DRIVE;
        end
      end
      DRIVE: begin
        if (ack_sync) begin
          bit0_nxt  = 1'b0;
          bit1_nxt  = 1'b0;
          state_nxt = RELEASE;
        end else if (cnt_q == CNT_W'(ACK_TIMEOUT - 1)) begin
          // Abort: discard the rest of the packet
          bit0_nxt  = 1'b0;
          bit1_nxt  = 1'b0;
          tmo_nxt   = 1'b1;
          rem_nxt   = '0;
          state_nxt = RELEASE;
        end else begin
          cnt_nxt = cnt_q + CNT_W'(1);
        end
      end
      RELEASE: begin
        bit0_nxt = 1'b0;
        bit1_nxt = 1'b0;
        if (!ack_sync) begin
          if (rem_q != '0) begin
            sh_nxt    = sh_q << 1;
            rem_nxt   = rem_q - REM_W'(1);
            cnt_nxt   = '0;
            bit1_nxt  = sh_q[SYM_W-2];
            bit0_nxt  = ~sh_q[SYM_W-2];
            state_nxt = DRIVE;
          end else begin
            state_nxt = IDLE;
          end
        end
      end
      default: begin
        bit0_nxt  = 1'b0;
        bit1_nxt  = 1'b0;
        state_nxt = IDLE;
      end
    endcase

    busy_nxt = (state_nxt != IDLE);
  end

  // Pending latches: a new edge beats a same-cycle clear; a repeat edge is dropped
  always_comb begin
    up_pend_nxt = '0;
    dn_pend_nxt = '0;
    drop_n      = '0;
    for (int i = 0; i < int'(NUM_CH); i++) begin
      up_pend_nxt[i] = up_rise[i] | (up_pend[i] & ~clr_up[i]);
      dn_pend_nxt[i] = dn_rise[i] | (dn_pend[i] & ~clr_dn[i]);
      if (up_rise[i] && up_pend[i] && !clr_up[i]) drop_n = drop_n + 32'd1;
      if (dn_rise[i] && dn_pend[i] && !clr_dn[i]) drop_n = drop_n + 32'd1;
    end
    drop_sum = 32'(drop_count) + drop_n;
    drop_nxt = (drop_sum > 32'd255) ? 8'hFF : drop_sum[7:0];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      bit0_q      <= 1'b0;
      bit1_q      <= 1'b0;
      sh_q        <= '0;
      rem_q       <= '0;
      cnt_q       <= '0;
      cur_addr    <= '0;
      rr_ptr      <= '0;
      busy        <= 1'b0;
      timeout_err <= 1'b0;
      up_pend     <= '0;
      dn_pend     <= '0;
      drop_count  <= '0;
    end else begin
      state_q     <= state_nxt;
      bit0_q      <= bit0_nxt;
      bit1_q      <= bit1_nxt;
      sh_q        <= sh_nxt;
      rem_q       <= rem_nxt;
      cnt_q       <= cnt_nxt;
      cur_addr    <= cur_addr_nxt;
      rr_ptr      <= rr_ptr_nxt;
      busy        <= busy_nxt;
      timeout_err <= tmo_nxt;
      up_pend     <= up_pend_nxt;
      dn_pend     <= dn_pend_nxt;
      drop_count  <= drop_nxt;
    end
  end

endmodule

// File: tb/tb_aer_multi_input.sv
// Bench for aer_multi_input: scoreboard of expected packets checked by a rail monitor.
module tb_aer_multi_input;
  localparam int unsigned NUM_CH      = 4;
  localparam int unsigned ADDR_W      = 2;
  localparam int unsigned ACK_TIMEOUT = 16;
  localparam int unsigned SYM_W       = ADDR_W + 1;

  logic              clk = 1'b0;
  logic              reset;
  logic [NUM_CH-1:0] ch_up, ch_down;
  logic              busy;
  logic [ADDR_W-1:0] cur_addr;
  logic              timeout_err;
  logic [7:0]        drop_count;

  aer_multi_input_if link ();

  aer_multi_input #(.NUM_CH(NUM_CH), .ADDR_W(ADDR_W), .ACK_TIMEOUT(ACK_TIMEOUT)) dut (
    .clk(clk), .reset(reset), .ch_up(ch_up), .ch_down(ch_down), .link(link),
    .busy(busy), .cur_addr(cur_addr), .timeout_err(timeout_err), .drop_count(drop_count)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic [SYM_W-1:0] sb[$];
  logic [SYM_W-1:0] exp_pkt;
  bit resp_en = 1'b1;
  bit sb_off  = 1'b0;
  int mon_nsym = 0;
  logic [SYM_W-1:0] mon_sym = '0;
  bit mon_prev = 1'b0;
  int rail_rises = 0;

  // Receiver model: ack follows the rails half a cycle later
  always @(negedge clk) link.ack = resp_en && (link.bit0 || link.bit1);

  // Rail monitor: assembles symbols into packets and checks against the scoreboard
  always @(negedge clk) begin
    if (reset) begin
      mon_nsym = 0;
      mon_prev = 1'b0;
    end else begin
      if (timeout_err) mon_nsym = 0;
      if ((link.bit0 || link.bit1) && !mon_prev) begin
        rail_rises++;
        checks++;
        if (link.bit0 === link.bit1) begin
          errors++;
          $display("FAIL rail_onehot bit0=%b bit1=%b required exactly one rail high", link.bit0, link.bit1);
        end
        mon_sym = {mon_sym[SYM_W-2:0], link.bit1};
        mon_nsym++;
        if (mon_nsym == int'(SYM_W)) begin
          mon_nsym = 0;
          if (!sb_off) begin
            checks++;
            if (sb.size() == 0) begin
              errors++;
              $display("FAIL unexpected_packet got=%b required no packet", mon_sym);
            end else begin
              exp_pkt = sb.pop_front();
              if (mon_sym !== exp_pkt || cur_addr !== exp_pkt[SYM_W-1:1]) begin
                errors++;
                $display("FAIL packet got=%b cur_addr=%0d required=%b addr=%0d",
                         mon_sym, cur_addr, exp_pkt, exp_pkt[SYM_W-1:1]);
              end
            end
          end
        end
      end
      mon_prev = link.bit0 || link.bit1;
    end
  end

  task automatic apply_reset();
    @(negedge clk);
    reset   = 1'b1;
    ch_up   = '0;
    ch_down = '0;
    sb.delete();
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  // One-cycle-high pulse, so consecutive calls give an edge every two cycles
  task automatic pulse(input logic [NUM_CH-1:0] up, input logic [NUM_CH-1:0] dn);
    @(negedge clk);
    ch_up   = ch_up | up;
    ch_down = ch_down | dn;
    @(negedge clk);
    ch_up   = ch_up & ~up;
    ch_down = ch_down & ~dn;
  endtask

  // Waits for an empty scoreboard and a quiet link for several cycles
  task automatic wait_idle(input int budget, output bit ok);
    int quiet;
    quiet = 0;
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (sb.size() == 0 && !busy && mon_nsym == 0) quiet++;
      else quiet = 0;
      if (quiet >= 6) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    apply_reset();
    @(negedge clk);
    checks++;
    if ({link.bit0, link.bit1} !== 2'b00) begin
      errors++; $display("FAIL reset_rails got=%b%b required=00", link.bit0, link.bit1);
    end
    checks++;
    if (busy !== 1'b0 || timeout_err !== 1'b0) begin
      errors++; $display("FAIL reset_flags busy=%b timeout_err=%b required 0 0", busy, timeout_err);
    end
    checks++;
    if (drop_count !== 8'd0 || cur_addr !== '0) begin
      errors++; $display("FAIL reset_counts drop=%0d cur_addr=%0d required 0 0", drop_count, cur_addr);
    end
  endtask

  task automatic test_single();
    bit busy_ok;
    apply_reset();
    sb.push_back({2'd2, 1'b1});
    @(negedge clk);
    ch_up[2] = 1'b1;
    @(posedge clk);
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ((link.bit0 | link.bit1) !== 1'b0) begin
      errors++; $display("FAIL single_early rails=%b%b required 00 two edges after input", link.bit0, link.bit1);
    end
    @(posedge clk);
    #1;
    checks++;
    if (link.bit1 !== 1'b1 || link.bit0 !== 1'b0 || busy !== 1'b1 || cur_addr !== 2'd2) begin
      errors++;
      $display("FAIL single_latency bit1=%b bit0=%b busy=%b cur_addr=%0d required 1 0 1 2",
               link.bit1, link.bit0, busy, cur_addr);
    end
    @(negedge clk);
    ch_up[2] = 1'b0;
    busy_ok = 1'b1;
    for (int i = 0; i < 80; i++) begin
      @(negedge clk);
      if (mon_nsym > 0 && busy !== 1'b1) busy_ok = 1'b0;
      if (sb.size() == 0) break;
    end
    checks++;
    if (sb.size() != 0 || !busy_ok) begin
      errors++; $display("FAIL single_packet pending=%0d busy_held=%0d required 0 1", sb.size(), busy_ok);
    end
  endtask

  task automatic test_round_robin();
    bit ok;
    apply_reset();
    for (int c = 0; c < 4; c++) sb.push_back({2'(c), 1'b1});
    pulse(4'b1111, 4'b0000);
    wait_idle(300, ok);
    checks++;
    if (!ok || drop_count !== 8'd0) begin
      errors++; $display("FAIL rr_burst drained=%0d drop=%0d required 1 0", ok, drop_count);
    end
    sb.push_back({2'd1, 1'b1});
    sb.push_back({2'd3, 1'b1});
    pulse(4'b1010, 4'b0000);
    wait_idle(200, ok);
    checks++;
    if (!ok) begin
      errors++; $display("FAIL rr_second drained=%0d pending=%0d required 1 0", ok, sb.size());
    end
  endtask

  task automatic test_up_down();
    bit ok;
    apply_reset();
    sb.push_back({2'd1, 1'b1});
    sb.push_back({2'd1, 1'b0});
    pulse(4'b0010, 4'b0010);
    wait_idle(200, ok);
    checks++;
    if (!ok || drop_count !== 8'd0) begin
      errors++; $display("FAIL up_down drained=%0d drop=%0d required 1 0", ok, drop_count);
    end
  endtask

  task automatic test_drop();
    bit ok;
    bit seen;
    apply_reset();
    sb.push_back({2'd0, 1'b1});
    sb.push_back({2'd3, 1'b1});
    pulse(4'b0001, 4'b0000);
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (busy) begin
        seen = 1'b1;
        break;
      end
    end
    checks++;
    if (!seen) begin
      errors++; $display("FAIL drop_start busy=%b required 1 within 10 cycles", busy);
    end
    for (int k = 0; k < 3; k++) pulse(4'b1000, 4'b0000);
    wait_idle(300, ok);
    checks++;
    if (!ok || drop_count !== 8'd2) begin
      errors++; $display("FAIL drop_two drained=%0d drop=%0d required 1 2", ok, drop_count);
    end
    sb_off = 1'b1;
    for (int k = 0; k < 300; k++) pulse(4'b1000, 4'b1000);
    wait_idle(500, ok);
    sb_off = 1'b0;
    checks++;
    if (!ok || drop_count !== 8'd255) begin
      errors++; $display("FAIL drop_saturate drained=%0d drop=%0d required 1 255", ok, drop_count);
    end
  endtask

  task automatic test_timeout();
    bit ok;
    bit seen;
    int hi;
    int tmo;
    apply_reset();
    resp_en = 1'b0;
    pulse(4'b0010, 4'b0000);
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (link.bit0 || link.bit1) begin
        seen = 1'b1;
        break;
      end
    end
    hi = seen ? 1 : 0;
    tmo = 0;
    for (int i = 0; i < 40 && seen; i++) begin
      @(negedge clk);
      if (timeout_err) tmo++;
      if (link.bit0 || link.bit1) hi++;
      else break;
    end
    repeat (3) begin
      @(negedge clk);
      if (timeout_err) tmo++;
    end
    checks++;
    if (hi != int'(ACK_TIMEOUT)) begin
      errors++; $display("FAIL timeout_len got=%0d cycles required=%0d", hi, ACK_TIMEOUT);
    end
    checks++;
    if (tmo != 1 || busy !== 1'b0) begin
      errors++; $display("FAIL timeout_pulse pulses=%0d busy=%b required 1 0", tmo, busy);
    end
    resp_en = 1'b1;
    sb.push_back({2'd2, 1'b1});
    pulse(4'b0100, 4'b0000);
    wait_idle(200, ok);
    checks++;
    if (!ok) begin
      errors++; $display("FAIL timeout_recover drained=%0d pending=%0d required 1 0", ok, sb.size());
    end
  endtask

  task automatic test_reset_mid();
    bit ok;
    bit seen;
    int rises;
    apply_reset();
    sb.push_back({2'd1, 1'b1});
    pulse(4'b0010, 4'b0000);
    pulse(4'b0001, 4'b0000);
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (mon_nsym == 2) begin
        seen = 1'b1;
        break;
      end
    end
    reset = 1'b1;
    sb.delete();
    @(posedge clk);
    #1;
    checks++;
    if (!seen || {link.bit0, link.bit1} !== 2'b00 || busy !== 1'b0 || drop_count !== 8'd0) begin
      errors++;
      $display("FAIL reset_mid reached=%0d rails=%b%b busy=%b drop=%0d required 1 00 0 0",
               seen, link.bit0, link.bit1, busy, drop_count);
    end
    @(negedge clk);
    reset = 1'b0;
    rises = rail_rises;
    repeat (30) @(negedge clk);
    checks++;
    if (rail_rises != rises || busy !== 1'b0) begin
      errors++; $display("FAIL reset_quiet rises=%0d busy=%b required 0 0", rail_rises - rises, busy);
    end
    @(negedge clk);
    reset = 1'b1;
    ch_up[2] = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    sb.push_back({2'd2, 1'b1});
    repeat (4) @(negedge clk);
    ch_up[2] = 1'b0;
    wait_idle(200, ok);
    checks++;
    if (!ok) begin
      errors++; $display("FAIL reset_held_input drained=%0d pending=%0d required 1 0", ok, sb.size());
    end
  endtask

  initial begin
    reset   = 1'b1;
    ch_up   = '0;
    ch_down = '0;
    test_reset();
    test_single();
    test_round_robin();
    test_up_down();
    test_drop();
    test_timeout();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
